// File: rtl/team06_audio_pkg.sv
// team06_audio_pkg: shared sample/offset types, reverb FSM states and default tap distance
package team06_audio_pkg;
  localparam int DATA_W = 8;
  localparam int OFFSET_W = 13;
  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [OFFSET_W-1:0] offset_t;
  typedef enum logic [1:0] {IDLE, SEARCH, MIX} state_t;
  localparam offset_t DELAY = 13'd4000;
endpackage

// File: rtl/team06_avg2.sv
// team06_avg2: combinational floor average of two unsigned samples; the 9-bit sum cannot overflow
module team06_avg2
  import team06_audio_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  logic [8:0] sum;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y = sum[8:1];
  end
endmodule

// File: rtl/team06_reverb.sv
// team06_reverb: single-tap reverb mixer alternating buffer search and mix, with registered bypass
module team06_reverb
  import team06_audio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  audio_in,
  input  logic        reverb_enable,
  input  logic [7:0]  past_output,
  output logic [12:0] r_offset,
  output logic        r_search,
  output logic [7:0]  reverb_out,
  output logic [7:0]  save_audio
);
  state_t  state, state_n;
  sample_t mix, reverb_n, save_n;
  offset_t offset_n;
  logic    search_n;
  team06_avg2 u_avg (.a(audio_in), .b(past_output), .y(mix));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      r_offset <= '0;
      r_search <= 1'b0;
      reverb_out <= '0;
      save_audio <= '0;
    end else begin
      state <= state_n;
      r_offset <= offset_n;
      r_search <= search_n;
      reverb_out <= reverb_n;
      save_audio <= save_n;
    end
  end
  // Bypass dominates every state so dropping enable aborts a search or mix at once
  always_comb begin
    state_n = IDLE;
    offset_n = r_offset;
    search_n = r_search;
    reverb_n = reverb_out;
    save_n = save_audio;
    if (!reverb_enable) begin
      offset_n = '0;
      search_n = 1'b0;
      reverb_n = audio_in;
      save_n = audio_in;
    end else begin
      case (state)
        IDLE: state_n = SEARCH;
        SEARCH: begin
          state_n = MIX;
          search_n = 1'b1;
          offset_n = DELAY;
        end
        MIX: begin
          state_n = SEARCH;
          search_n = 1'b0;
          reverb_n = mix;
          save_n = mix;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_team06_reverb.sv
// tb_team06_reverb: directed checks of reset, mixing, boundaries, bypass, abort and mid-mix reset
module tb_team06_reverb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  audio_in = '0;
  logic        reverb_enable = 1'b0;
  logic [7:0]  past_output = '0;
  logic [12:0] r_offset;
  logic        r_search;
  logic [7:0]  reverb_out;
  logic [7:0]  save_audio;
  int checks = 0;
  int failures = 0;
  team06_reverb dut (
    .clk(clk), .rst(rst), .audio_in(audio_in), .reverb_enable(reverb_enable),
    .past_output(past_output), .r_offset(r_offset), .r_search(r_search),
    .reverb_out(reverb_out), .save_audio(save_audio)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_out(input string tag, input logic [7:0] out, input logic srch, input logic [12:0] off);
    check({tag, "_out"}, reverb_out, out);
    check({tag, "_save"}, save_audio, out);
    check({tag, "_search"}, r_search, srch);
    check({tag, "_offset"}, r_offset, off);
  endtask
  initial begin
    rst = 1'b0; reverb_enable = 1'b1; audio_in = 8'd68; past_output = 8'd50;
    step(); check_out("rst1", 8'd0, 1'b0, 13'd0);
    step(); check_out("rst2", 8'd0, 1'b0, 13'd0);
    step(); check_out("rst3", 8'd0, 1'b0, 13'd0);
    rst = 1'b1; audio_in = 8'd78; past_output = 8'd89;
    step(); check_out("idle_to_search", 8'd0, 1'b0, 13'd0);
    step(); check_out("search", 8'd0, 1'b1, 13'd4000);
    step(); check_out("mix_78_89", 8'd83, 1'b0, 13'd4000);
    audio_in = 8'd65; past_output = 8'd56;
    step(); check_out("search2_hold", 8'd83, 1'b1, 13'd4000);
    step(); check_out("mix_65_56", 8'd60, 1'b0, 13'd4000);
    audio_in = 8'd255; past_output = 8'd255;
    step(); step(); check("mix_255_255", reverb_out, 8'd255);
    audio_in = 8'd254; past_output = 8'd255;
    step(); step(); check("mix_254_255", reverb_out, 8'd254);
    audio_in = 8'd12; past_output = 8'd255;
    step(); step(); check_out("mix_12_255", 8'd133, 1'b0, 13'd4000);
    reverb_enable = 1'b0; audio_in = 8'd75;
    step(); check_out("bypass_75", 8'd75, 1'b0, 13'd0);
    reverb_enable = 1'b1; audio_in = 8'd100; past_output = 8'd20;
    step(); check_out("reen_idle", 8'd75, 1'b0, 13'd0);
    reverb_enable = 1'b0; audio_in = 8'd40;
    step(); check_out("abort_search", 8'd40, 1'b0, 13'd0);
    reverb_enable = 1'b1; audio_in = 8'd100;
    step(); step(); check_out("pre_mix", 8'd40, 1'b1, 13'd4000);
    reverb_enable = 1'b0; audio_in = 8'd41;
    step(); check_out("abort_mix", 8'd41, 1'b0, 13'd0);
    reverb_enable = 1'b1; audio_in = 8'd100;
    step(); check_out("reen_hold", 8'd41, 1'b0, 13'd0);
    step(); check_out("reen_search", 8'd41, 1'b1, 13'd4000);
    step(); check_out("reen_mix", 8'd60, 1'b0, 13'd4000);
    step(); check("pre_rst_search", r_search, 1'b1);
    rst = 1'b0; past_output = 8'd200;
    step(); check_out("rst_mid_mix", 8'd0, 1'b0, 13'd0);
    rst = 1'b1;
    step(); check_out("post_rst_idle", 8'd0, 1'b0, 13'd0);
    step(); check_out("post_rst_search", 8'd0, 1'b1, 13'd4000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
